vga_frame_sequencer: RTL and testbench
======================================

Name: vga_frame_sequencer

Overview:
Timing and playback controller for the VGA player datapath. Generates 640x480@60 Hz sync/position from the 25.175 MHz pixel clock. Runs the playback state machine (idle/play/pause/done) that decides which animation frame index the pixel generator renders. Commands are latched and applied only at frame boundaries, so frame changes never tear mid-scan.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
N_FRAMES, 64, animation frames; frame_idx width = clog2(N_FRAMES)
FRAME_DIV, 4, video frames shown per animation frame (>=1)

Ports:
clk  in  1  pixel clock, single clock domain
rst  in  1  synchronous, active-high reset
cmd_play  in  1  one-cycle pulse: start/resume
cmd_pause  in  1  one-cycle pulse: pause
cmd_stop  in  1  one-cycle pulse: stop, rewind to frame 0
cmd_step  in  1  one-cycle pulse: advance one frame while paused
loop_en  in  1  level: wrap at last frame instead of stopping
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
display_on  out  1  high inside active area
hpos  out  10  current pixel column
vpos  out  10  current line
frame_idx  out  6  animation frame being displayed
frame_tick  out  1  one-cycle pulse at (0,0) when frame_idx changed
state  out  2  IDLE=0, PLAY=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst high at clk edge): hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_idx=0, frame_tick=0, state=IDLE, pending commands and div counter cleared. Reset mid-frame restarts the scan at (0,0) on the next cycle.
- hpos counts 0..H_TOTAL-1 (800), then wraps to 0 and vpos increments. vpos counts 0..V_TOTAL-1 (525), then wraps. H_TOTAL and V_TOTAL are the sums of their four timing parameters.
- hsync=0 iff hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751). vsync=0 iff vpos in [490..491].
- display_on = (hpos<H_ACTIVE) && (vpos<V_ACTIVE).
- All outputs are registered and mutually aligned: sync, display_on, hpos, vpos and frame_idx describe the same pixel in the same cycle.
- Command capture: any cmd pulse sets a pending flag that holds until the boundary. Multiple pending commands resolve by priority stop > play > pause > step.
- Frame boundary = cycle where hpos=H_TOTAL-1 and vpos=V_TOTAL-1. All state/frame_idx updates happen here and are visible at (0,0).
- A command arriving on the boundary cycle itself is applied at that boundary. Pending flags clear at each boundary.
- FSM at boundary:
  - stop, from any state -> IDLE, frame_idx=0, div=0.
  - IDLE + play -> PLAY.
  - PLAY + pause -> PAUSE.
  - PAUSE + play -> PLAY.
  - DONE + play -> PLAY with frame_idx=0.
  - PAUSE + step -> frame_idx+1, stays PAUSE; at the last frame, wraps to 0 if loop_en, else no change.
  - Step in any other state is ignored.
- PLAY with no command: div increments each boundary. When div=FRAME_DIV-1, div resets to 0 and frame_idx advances.
  - At N_FRAMES-1: loop_en=1 -> frame_idx=0. loop_en=0 -> state=DONE, frame_idx held.
- frame_tick = 1 for exactly the (0,0) cycle following a boundary that changed frame_idx; otherwise 0.
- Width rules: frame_idx increments modulo N_FRAMES only through the explicit wrap. div width = clog2(FRAME_DIV)+1.

Decomposition:
- Package vga_player_pkg: timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL), state enum typedef play_state_t {IDLE, PLAY, PAUSE, DONE}, FRAME_W.
- Sub-module vga_timing_gen: h/v counters, sync, display_on, boundary strobe.
- The top holds command latches, the FSM, the div counter and frame_idx.

Test Plan:
- Reset then free-run 420000 cycles -> hsync low for exactly 96 cycles per 800-cycle line; vsync low for lines 490-491; 307200 display_on cycles per frame; state=IDLE, frame_idx=0 throughout.
- cmd_play at cycle 1000, FRAME_DIV=4 -> state=PLAY at next (0,0); frame_idx=1 with frame_tick pulse at the start of the 5th frame after the play boundary.
- N_FRAMES=4, FRAME_DIV=1, loop_en=0, play -> frame_idx 0,1,2,3, then state=DONE holding 3. Repeat with loop_en=1 -> 3 wraps to 0, no DONE.
- Pause mid-play, then two cmd_step pulses in separate frames -> frame_idx +1 at each boundary, state stays PAUSE. A step issued in PLAY -> no extra advance.
- cmd_stop and cmd_play in the same frame while PLAY at frame_idx=5 -> stop wins: IDLE, frame_idx=0, frame_tick asserted.
- rst asserted at hpos=300, vpos=200 during PLAY -> next cycle hpos=0, vpos=0, state=IDLE, frame_idx=0, hsync=vsync=1.

Source files
------------

// File: rtl/vga_player_pkg.sv
// vga_player_pkg
// Shared definitions for the VGA player datapath: default 640x480@60 Hz
// timing constants, animation defaults, the playback state encoding and
// the bundle of one-cycle command strobes.
// No ports (package).

package vga_player_pkg;

    // Default 640x480@60 Hz timing at a 25.175 MHz pixel clock
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Animation defaults
    localparam int N_FRAMES_DEF  = 64;
    localparam int FRAME_DIV_DEF = 4;
    localparam int FRAME_W       = $clog2(N_FRAMES_DEF);

    // Playback state; the numeric encoding is visible on the state port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } play_state_t;

    // One flag per command, used both for the raw strobes and the
    // latched pending flags
    typedef struct packed {
        logic stop;
        logic play;
        logic pause;
        logic step;
    } cmd_set_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Horizontal/vertical raster counters with registered sync, display enable
// and position outputs, all describing the same pixel in the same cycle.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   hsync, vsync        active-low sync pulses
//   display_on          high inside the visible area
//   hpos, vpos          current pixel column / line
//   frame_end           high on the last pixel of the frame (boundary cycle)

module vga_timing_gen
    import vga_player_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_next;
    logic [9:0] v_next;

    // Position of the pixel that will be shown next cycle
    always_comb begin
        h_next = hpos + 10'd1;
        v_next = vpos;
        if (hpos == H_LAST) begin
            h_next = '0;
            v_next = (vpos == V_LAST) ? '0 : vpos + 10'd1;
        end
    end

    // Sync and enable are decoded from the next position so that they are
    // registered alongside hpos/vpos rather than lagging them by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos       <= '0;
            vpos       <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            display_on <= 1'b1;
        end else begin
            hpos       <= h_next;
            vpos       <= v_next;
            hsync      <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync      <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            display_on <= (h_next < H_VIS) && (v_next < V_VIS);
        end
    end

    assign frame_end = (hpos == H_LAST) && (vpos == V_LAST);

endmodule

// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer
// Raster timing plus playback controller. Command strobes are latched and
// only take effect on the last pixel of a frame, so state and frame_idx
// changes first appear at pixel (0,0) and never tear mid-scan.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   cmd_play/pause/stop/step one-cycle command strobes
//   loop_en                  wrap at the last frame instead of stopping
//   hsync, vsync             active-low sync
//   display_on, hpos, vpos   visible-area flag and current position
//   frame_idx                animation frame being displayed
//   frame_tick               pulse at (0,0) when frame_idx changed
//   state                    IDLE=0, PLAY=1, PAUSE=2, DONE=3

module vga_frame_sequencer
    import vga_player_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int N_FRAMES  = N_FRAMES_DEF,
    parameter int FRAME_DIV = FRAME_DIV_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_play,
    input  logic                        cmd_pause,
    input  logic                        cmd_stop,
    input  logic                        cmd_step,
    input  logic                        loop_en,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        display_on,
    output logic [9:0]                  hpos,
    output logic [9:0]                  vpos,
    output logic [$clog2(N_FRAMES)-1:0] frame_idx,
    output logic                        frame_tick,
    output logic [1:0]                  state
);

    localparam int FW    = $clog2(N_FRAMES);
    localparam int DIV_W = $clog2(FRAME_DIV) + 1;

    localparam logic [FW-1:0]    LAST_FRAME = FW'(N_FRAMES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);

    logic frame_end;

    play_state_t      cur_state;
    play_state_t      nxt_state;
    logic [FW-1:0]    frame_q;
    logic [FW-1:0]    frame_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_d;
    cmd_set_t         cmd_in;
    cmd_set_t         pend_q;
    cmd_set_t         pend_d;
    cmd_set_t         eff;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .frame_end  (frame_end)
    );

    assign cmd_in = '{stop: cmd_stop, play: cmd_play, pause: cmd_pause, step: cmd_step};

    // A strobe landing on the boundary cycle itself is folded in here, so
    // it is applied at that boundary rather than carried into the next frame
    assign eff = pend_q | cmd_in;

    // Next-state logic. Outside the boundary only the pending flags move.
    // At the boundary one command is resolved by priority
    // stop > play > pause > step; a command with no meaning in the current
    // state is dropped and PLAY then keeps advancing as if none arrived.
    always_comb begin
        nxt_state = cur_state;
        frame_d   = frame_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        pend_d    = pend_q | cmd_in;

        if (frame_end) begin
            pend_d = '0;
            if (eff.stop) begin
                nxt_state = IDLE;
                frame_d   = '0;
                div_d     = '0;
            end else begin
                unique case (cur_state)
                    IDLE: begin
                        if (eff.play) begin
                            nxt_state = PLAY;
                        end
                    end
                    PLAY: begin
                        if (eff.pause && !eff.play) begin
                            nxt_state = PAUSE;
                        end else if (div_q == DIV_LAST) begin
                            div_d = '0;
                            if (frame_q != LAST_FRAME) begin
                                frame_d = frame_q + 1'b1;
                            end else if (loop_en) begin
                                frame_d = '0;
                            end else begin
                                nxt_state = DONE;
                            end
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (eff.play) begin
                            nxt_state = PLAY;
                        end else if (eff.step && !eff.pause) begin
                            if (frame_q != LAST_FRAME) begin
                                frame_d = frame_q + 1'b1;
                            end else if (loop_en) begin
                                frame_d = '0;
                            end
                        end
                    end
                    DONE: begin
                        if (eff.play) begin
                            nxt_state = PLAY;
                            frame_d   = '0;
                            div_d     = '0;
                        end
                    end
                    default: begin
                        nxt_state = IDLE;
                    end
                endcase
            end
            tick_d = (frame_d != frame_q);
        end
    end

    // Playback registers; everything here changes only at a frame boundary
    // except the pending flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= IDLE;
            frame_q    <= '0;
            div_q      <= '0;
            frame_tick <= 1'b0;
            pend_q     <= '0;
        end else begin
            cur_state  <= nxt_state;
            frame_q    <= frame_d;
            div_q      <= div_d;
            frame_tick <= tick_d;
            pend_q     <= pend_d;
        end
    end

    assign frame_idx = frame_q;
    assign state     = cur_state;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// tb_vga_frame_sequencer
// Self-checking bench for vga_frame_sequencer with shrunken raster timing
// (15x10 pixels per frame) so many animation frames fit in a short run.
// A behavioural model tracks the expected outputs cycle by cycle; a few
// hand-computed literal expectations pin the model at known points.

module tb_vga_frame_sequencer;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int NF = 4;
    localparam int FD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_play;
    logic       cmd_pause;
    logic       cmd_stop;
    logic       cmd_step;
    logic       loop_en;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [1:0] frame_idx;
    logic       frame_tick;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: raster position plus playback state, as integers
    int m_h, m_v, m_state, m_frame, m_div;
    bit m_tick;
    bit p_stop, p_play, p_pause, p_step;

    always #5 clk = ~clk;

    vga_frame_sequencer #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .N_FRAMES  (NF),
        .FRAME_DIV (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_play   (cmd_play),
        .cmd_pause  (cmd_pause),
        .cmd_stop   (cmd_stop),
        .cmd_step   (cmd_step),
        .loop_en    (loop_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .frame_idx  (frame_idx),
        .frame_tick (frame_tick),
        .state      (state)
    );

    // Single comparison point; every check in the bench goes through here
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance frame_idx one animation frame; returns 1 if it ran off the end
    function automatic bit advanceFrame(input bit le);
        if (m_frame < NF - 1) begin
            m_frame++;
            return 1'b0;
        end
        if (le) begin
            m_frame = 0;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Model one clock edge given the inputs present at that edge
    task automatic modelStep(input bit r, input bit cp, input bit cpa,
                             input bit cs, input bit cst, input bit le);
        int cmd;
        int old;
        bit ran_off;
        if (r) begin
            m_h = 0; m_v = 0; m_state = 0; m_frame = 0; m_div = 0; m_tick = 0;
            p_stop = 0; p_play = 0; p_pause = 0; p_step = 0;
            return;
        end
        if (m_h == HT - 1 && m_v == VT - 1) begin
            // 0 none, 1 stop, 2 play, 3 pause, 4 step
            cmd = (p_stop  | cs)  ? 1 :
                  (p_play  | cp)  ? 2 :
                  (p_pause | cpa) ? 3 :
                  (p_step  | cst) ? 4 : 0;
            old = m_frame;
            if (cmd == 1) begin
                m_state = 0; m_frame = 0; m_div = 0;
            end else if (m_state == 0 && cmd == 2) begin
                m_state = 1;
            end else if (m_state == 1 && cmd == 3) begin
                m_state = 2;
            end else if (m_state == 2 && cmd == 2) begin
                m_state = 1;
            end else if (m_state == 3 && cmd == 2) begin
                m_state = 1; m_frame = 0; m_div = 0;
            end else if (m_state == 2 && cmd == 4) begin
                ran_off = advanceFrame(le);
            end else if (m_state == 1) begin
                m_div++;
                if (m_div == FD) begin
                    m_div = 0;
                    ran_off = advanceFrame(le);
                    if (ran_off) m_state = 3;
                end
            end
            m_tick = (m_frame != old);
            p_stop = 0; p_play = 0; p_pause = 0; p_step = 0;
        end else begin
            m_tick = 0;
            p_stop |= cs; p_play |= cp; p_pause |= cpa; p_step |= cst;
        end
        m_h++;
        if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v + 1) % VT;
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        bit exp_hs, exp_vs, exp_de;
        exp_hs = !(m_h >= HA + HF && m_h < HA + HF + HS);
        exp_vs = !(m_v >= VA + VF && m_v < VA + VF + VS);
        exp_de = (m_h < HA) && (m_v < VA);
        check("hpos", 32'(hpos), 32'(m_h));
        check("vpos", 32'(vpos), 32'(m_v));
        check("hsync", 32'(hsync), 32'(exp_hs));
        check("vsync", 32'(vsync), 32'(exp_vs));
        check("display_on", 32'(display_on), 32'(exp_de));
        check("frame_idx", 32'(frame_idx), 32'(m_frame));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("state", 32'(state), 32'(m_state));
    endtask

    // Drive one cycle of inputs (called at a negedge), step the model and
    // compare at the following negedge
    task automatic applyStimulus(input bit r, input bit cp, input bit cpa,
                                 input bit cs, input bit cst, input bit le);
        rst = r; cmd_play = cp; cmd_pause = cpa; cmd_stop = cs; cmd_step = cst; loop_en = le;
        modelStep(r, cp, cpa, cs, cst, le);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n, input bit le);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, le);
    endtask

    int hs_low, vs_low, de_cnt;

    initial begin
        rst = 1'b1; cmd_play = 0; cmd_pause = 0; cmd_stop = 0; cmd_step = 0; loop_en = 0;
        @(negedge clk);

        // Reset values
        applyStimulus(1, 0, 0, 0, 0, 0);
        check("rst_hpos", 32'(hpos), 0);
        check("rst_vpos", 32'(vpos), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_display_on", 32'(display_on), 1);
        check("rst_state", 32'(state), 0);
        check("rst_frame_idx", 32'(frame_idx), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);

        // Free-run one frame and count sync/enable cycles
        hs_low = 0; vs_low = 0; de_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (display_on) de_cnt++;
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        check("hsync_low_per_frame", 32'(hs_low), 30);
        check("vsync_low_per_frame", 32'(vs_low), 30);
        check("display_on_per_frame", 32'(de_cnt), 48);
        check("freerun_state", 32'(state), 0);

        // Play, no loop: frame 1 after the third boundary, DONE on frame 3
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(5, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(444, 0);
        check("play_f1_state", 32'(state), 1);
        check("play_f1_frame", 32'(frame_idx), 1);
        check("play_f1_tick", 32'(frame_tick), 1);
        idle(900, 0);
        check("done_state", 32'(state), 3);
        check("done_frame", 32'(frame_idx), 3);
        idle(150, 0);
        check("done_hold_frame", 32'(frame_idx), 3);
        check("done_hold_tick", 32'(frame_tick), 0);

        // Play with loop: last frame wraps to 0 instead of DONE
        applyStimulus(1, 0, 0, 0, 0, 1);
        idle(5, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        idle(1344, 1);
        check("loop_state", 32'(state), 1);
        check("loop_frame", 32'(frame_idx), 0);
        check("loop_tick", 32'(frame_tick), 1);

        // Stop and play in the same frame: stop wins
        applyStimulus(1, 0, 0, 0, 0, 1);
        idle(5, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        idle(744, 1);
        check("pre_stop_frame", 32'(frame_idx), 2);
        idle(10, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        idle(10, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        idle(128, 1);
        check("stop_state", 32'(state), 0);
        check("stop_frame", 32'(frame_idx), 0);
        check("stop_tick", 32'(frame_tick), 1);

        // Pause, then steps in separate frames; last step saturates
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(5, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(444, 0);
        idle(20, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idle(129, 0);
        check("pause_state", 32'(state), 2);
        check("pause_frame", 32'(frame_idx), 1);
        idle(20, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(129, 0);
        check("step1_frame", 32'(frame_idx), 2);
        check("step1_tick", 32'(frame_tick), 1);
        check("step1_state", 32'(state), 2);
        idle(20, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(129, 0);
        check("step2_frame", 32'(frame_idx), 3);
        idle(20, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(129, 0);
        check("step_last_frame", 32'(frame_idx), 3);
        check("step_last_tick", 32'(frame_tick), 0);

        // Reset mid-frame during PLAY
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(5, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        idle(811, 0);
        check("mid_hpos", 32'(hpos), 7);
        check("mid_vpos", 32'(vpos), 4);
        check("mid_frame", 32'(frame_idx), 2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        check("midrst_hpos", 32'(hpos), 0);
        check("midrst_vpos", 32'(vpos), 0);
        check("midrst_state", 32'(state), 0);
        check("midrst_frame", 32'(frame_idx), 0);
        check("midrst_hsync", 32'(hsync), 1);
        check("midrst_vsync", 32'(vsync), 1);

        // Command landing exactly on the boundary cycle
        idle(149, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        check("boundary_cmd_state", 32'(state), 1);

        // Randomised commands against the model
        for (int i = 0; i < 30000; i++) begin
            bit r, cp, cpa, cs, cst;
            if ($urandom_range(0, 1999) == 0) loop_en = ~loop_en;
            r   = ($urandom_range(0, 4999) == 0);
            cp  = ($urandom_range(0, 149) == 0);
            cpa = ($urandom_range(0, 299) == 0);
            cs  = ($urandom_range(0, 599) == 0);
            cst = ($urandom_range(0, 99) == 0);
            applyStimulus(r, cp, cpa, cs, cst, loop_en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
